// File: rtl/skewed_weight_feeder_pkg.sv
// Shared types and default sizing for the skewed weight feeder.
// Defaults describe the reference array build; the top takes them as parameter defaults.
package skewed_weight_feeder_pkg;

    localparam int sys_cols       = 4;
    localparam int W_BITWIDTH     = 8;
    localparam int w_buffer_depth = 8;

    localparam int W_LEN_BITS = $clog2(w_buffer_depth + 1);

    typedef logic [sys_cols-1:0][W_BITWIDTH-1:0] w_row_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } wfeed_state_t;

endpackage

// File: rtl/wfeed_skew_line.sv
// Purpose: DELAY-stage register pipe carrying {valid, data} for one array column.
// Latency: DELAY cycles (DELAY=0 is a plain wire).
// Backpressure: none; the pipe always advances.
module wfeed_skew_line #(
    parameter int DELAY = 0,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] in_dat,
    output logic             out_vld,
    output logic [WIDTH-1:0] out_dat
);
    import skewed_weight_feeder_pkg::*;

    generate
        if (DELAY == 0) begin : g_wire
            logic unused_clk_rst;
            assign unused_clk_rst = &{1'b0, clk, rst};
            assign out_vld = in_vld;
            assign out_dat = in_dat;
        end else begin : g_pipe
            logic [DELAY-1:0][WIDTH:0] pipe_q;
            logic [DELAY-1:0][WIDTH:0] pipe_d;

            always_comb begin
                pipe_d[0] = {in_vld, in_dat};
                for (int i = 1; i < DELAY; i++) begin
                    pipe_d[i] = pipe_q[i-1];
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    pipe_q <= '0;
                end else begin
                    pipe_q <= pipe_d;
                end
            end

            assign {out_vld, out_dat} = pipe_q[DELAY-1];
        end
    endgenerate

endmodule

// File: rtl/skewed_weight_feeder.sv
// Purpose: ping-pong weight banks streamed into the array top edge with column j skewed by j cycles.
// Latency: start at T -> column j valid T+1+j .. T+len+j, done at T+len+SYS_COLS-1.
// Backpressure: wr_ready drops while the write bank is full; start_ready only when the read bank is full and idle.
// Optional WFEED_REPLAY_EN adds input keep: a kept tile stays resident for another stream.
module skewed_weight_feeder #(
    parameter int SYS_COLS   = skewed_weight_feeder_pkg::sys_cols,
    parameter int W_BITWIDTH = skewed_weight_feeder_pkg::W_BITWIDTH,
    parameter int DEPTH      = skewed_weight_feeder_pkg::w_buffer_depth
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wr_valid,
    output logic                           wr_ready,
    input  logic [SYS_COLS*W_BITWIDTH-1:0] wr_data,
    input  logic                           wr_last,
    input  logic                           start,
`ifdef WFEED_REPLAY_EN
    input  logic                           keep,
`endif
    output logic                           start_ready,
    output logic [SYS_COLS-1:0]            o_valid,
    output logic [SYS_COLS*W_BITWIDTH-1:0] o_data,
    output logic                           done,
    output logic [1:0]                     bank_full
);
    import skewed_weight_feeder_pkg::*;

    localparam int ROW_W      = SYS_COLS * W_BITWIDTH;
    localparam int LEN_W      = $clog2(DEPTH + 1);
    localparam int ADDR_W     = $clog2(2 * DEPTH);
    localparam int DRAIN_W    = (SYS_COLS > 2) ? $clog2(SYS_COLS - 1) : 1;
    localparam int DRAIN_LAST = (SYS_COLS > 1) ? SYS_COLS - 2 : 0;

    wfeed_state_t            state_q, state_d;
    logic [1:0]              full_q, full_d;
    logic [1:0][LEN_W-1:0]   bank_len_q, bank_len_d;
    logic                    wr_bank_q, wr_bank_d;
    logic                    rd_bank_q, rd_bank_d;
    logic [LEN_W-1:0]        wr_cnt_q, wr_cnt_d;
    logic [LEN_W-1:0]        rd_cnt_q, rd_cnt_d;
    logic [LEN_W-1:0]        len_q, len_d;
    logic [DRAIN_W-1:0]      drain_cnt_q, drain_cnt_d;
    logic                    done_q, done_d;
    logic                    stage_vld_q, stage_vld_d;
    logic [ROW_W-1:0]        stage_dat_q, stage_dat_d;
`ifdef WFEED_REPLAY_EN
    logic                    keep_q, keep_d;
`endif

    logic [ROW_W-1:0] mem [2*DEPTH];

    logic              wr_fire, wr_close, start_fire, rd_en, rd_last, release_bank;
    logic [LEN_W-1:0]  rd_row, cur_len;
    logic [ADDR_W-1:0] wr_addr, rd_addr;

    assign wr_ready    = !full_q[wr_bank_q];
    // The done cycle still shows the finishing bank as full; hold start off until it is released.
    assign start_ready = (state_q == IDLE) && full_q[rd_bank_q] && !done_q;

    assign wr_fire    = wr_valid && wr_ready;
    assign wr_close   = wr_fire && (wr_last || (wr_cnt_q == LEN_W'(DEPTH - 1)));
    assign start_fire = start && start_ready;

    assign rd_en   = start_fire || (state_q == STREAM);
    assign rd_row  = start_fire ? '0 : rd_cnt_q;
    assign cur_len = start_fire ? bank_len_q[rd_bank_q] : len_q;
    assign rd_last = rd_en && (rd_row == cur_len - LEN_W'(1));

    assign wr_addr = (wr_bank_q ? ADDR_W'(DEPTH) : '0) + ADDR_W'(wr_cnt_q);
    assign rd_addr = (rd_bank_q ? ADDR_W'(DEPTH) : '0) + ADDR_W'(rd_row);

`ifdef WFEED_REPLAY_EN
    assign release_bank = done_q && !keep_q;
`else
    assign release_bank = done_q;
`endif

    always_comb begin
        state_d     = state_q;
        rd_cnt_d    = rd_cnt_q;
        len_d       = len_q;
        drain_cnt_d = drain_cnt_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_fire) begin
                    len_d    = cur_len;
                    rd_cnt_d = LEN_W'(1);
                    state_d  = STREAM;
                end
            end
            STREAM: begin
                rd_cnt_d = rd_cnt_q + LEN_W'(1);
            end
            DRAIN: begin
                drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
                if (drain_cnt_q == DRAIN_W'(DRAIN_LAST)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Row 0 may be read in the start cycle itself, so a 1-row tile skips STREAM.
        if (rd_last) begin
            drain_cnt_d = '0;
            if (SYS_COLS == 1) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end else begin
                state_d = DRAIN;
            end
        end
    end

    always_comb begin
        full_d     = full_q;
        bank_len_d = bank_len_q;
        wr_bank_d  = wr_bank_q;
        rd_bank_d  = rd_bank_q;
        wr_cnt_d   = wr_cnt_q;
        if (release_bank) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = !rd_bank_q;
        end
        if (wr_fire) begin
            wr_cnt_d = wr_cnt_q + LEN_W'(1);
            if (wr_close) begin
                full_d[wr_bank_q]     = 1'b1;
                bank_len_d[wr_bank_q] = wr_cnt_q + LEN_W'(1);
                wr_cnt_d              = '0;
                wr_bank_d             = !wr_bank_q;
            end
        end
    end

    always_comb begin
        stage_vld_d = rd_en;
        stage_dat_d = rd_en ? mem[rd_addr] : '0;
    end

`ifdef WFEED_REPLAY_EN
    assign keep_d = start_fire ? keep : keep_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            full_q      <= '0;
            bank_len_q  <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            len_q       <= '0;
            drain_cnt_q <= '0;
            done_q      <= 1'b0;
            stage_vld_q <= 1'b0;
            stage_dat_q <= '0;
`ifdef WFEED_REPLAY_EN
            keep_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            full_q      <= full_d;
            bank_len_q  <= bank_len_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            len_q       <= len_d;
            drain_cnt_q <= drain_cnt_d;
            done_q      <= done_d;
            stage_vld_q <= stage_vld_d;
            stage_dat_q <= stage_dat_d;
`ifdef WFEED_REPLAY_EN
            keep_q      <= keep_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_addr] <= wr_data;
        end
    end

    genvar j;
    generate
        for (j = 0; j < SYS_COLS; j++) begin : g_col
            wfeed_skew_line #(
                .DELAY (j),
                .WIDTH (W_BITWIDTH)
            ) u_skew (
                .clk     (clk),
                .rst     (rst),
                .in_vld  (stage_vld_q),
                .in_dat  (stage_dat_q[j*W_BITWIDTH +: W_BITWIDTH]),
                .out_vld (o_valid[j]),
                .out_dat (o_data[j*W_BITWIDTH +: W_BITWIDTH])
            );
        end
    endgenerate

    assign done      = done_q;
    assign bank_full = full_q;

endmodule

// File: tb/tb_skewed_weight_feeder.sv
// Bench for skewed_weight_feeder: random and directed traffic against a tile-level timing model.
module tb_skewed_weight_feeder;
    localparam int SC    = 4;
    localparam int W     = 8;
    localparam int DEPTH = 8;
    localparam int MAXC  = 4096;

    logic            clk = 1'b0;
    logic            rst;
    logic            wr_valid, wr_last, start, keep;
    logic            wr_ready, start_ready, done;
    logic [SC*W-1:0] wr_data;
    logic [SC-1:0]   o_valid;
    logic [SC*W-1:0] o_data;
    logic [1:0]      bank_full;

    skewed_weight_feeder #(.SYS_COLS(SC), .W_BITWIDTH(W), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_data     (wr_data),
        .wr_last     (wr_last),
        .start       (start),
`ifdef WFEED_REPLAY_EN
        .keep        (keep),
`endif
        .start_ready (start_ready),
        .o_valid     (o_valid),
        .o_data      (o_data),
        .done        (done),
        .bank_full   (bank_full)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Tile-level reference: banks hold whole tiles, a start schedules the full skewed output pattern.
    bit              m_full [2];
    logic [SC*W-1:0] m_tile [2][DEPTH];
    int              m_len  [2];
    logic [SC*W-1:0] m_cur  [DEPTH];
    int              m_cnt, m_wb, m_rb, m_done_cyc;
    bit              m_act, m_keep;
    logic [SC-1:0]   e_vld  [MAXC];
    logic [SC*W-1:0] e_dat  [MAXC];
    bit              e_done [MAXC];

    task automatic model_reset();
        m_full[0] = 0; m_full[1] = 0;
        m_len[0] = 0; m_len[1] = 0;
        m_cnt = 0; m_wb = 0; m_rb = 0; m_act = 0; m_keep = 0; m_done_cyc = 0;
        for (int i = 0; i < MAXC; i++) begin
            e_vld[i] = '0; e_dat[i] = '0; e_done[i] = 0;
        end
    endtask

    function automatic logic [SC*W-1:0] mkrow(input int r);
        logic [SC*W-1:0] d;
        for (int j = 0; j < SC; j++) d[j*W +: W] = 8'(16 * r + j);
        return d;
    endfunction

    task automatic step(input bit wv, input logic [SC*W-1:0] wd, input bit wl, input bit st, input bit kp);
        bit wr_rdy_m, st_rdy_m;
        int t, l;
        @(negedge clk);
        wr_rdy_m = !m_full[m_wb];
        st_rdy_m = !m_act && m_full[m_rb];
        check("o_valid", 64'(o_valid), 64'(e_vld[cyc]));
        check("o_data", 64'(o_data), 64'(e_dat[cyc]));
        check("done", 64'(done), 64'(e_done[cyc]));
        check("bank_full", 64'(bank_full), {62'd0, m_full[1], m_full[0]});
        check("wr_ready", 64'(wr_ready), 64'(wr_rdy_m));
        check("start_ready", 64'(start_ready), 64'(st_rdy_m));
        wr_valid = wv; wr_data = wd; wr_last = wl; start = st; keep = kp;
        if (m_act && cyc == m_done_cyc) begin
            m_act = 0;
            if (!m_keep) begin
                m_full[m_rb] = 0;
                m_rb ^= 1;
            end
        end
        if (wv && wr_rdy_m) begin
            m_cur[m_cnt] = wd;
            m_cnt++;
            if (wl || m_cnt == DEPTH) begin
                for (int r = 0; r < m_cnt; r++) m_tile[m_wb][r] = m_cur[r];
                m_len[m_wb]  = m_cnt;
                m_full[m_wb] = 1;
                m_cnt = 0;
                m_wb ^= 1;
            end
        end
        if (st && st_rdy_m && cyc < MAXC - 32) begin
            t = cyc;
            l = m_len[m_rb];
            for (int r = 0; r < l; r++) begin
                for (int j = 0; j < SC; j++) begin
                    e_vld[t+1+j+r][j] = 1'b1;
                    e_dat[t+1+j+r][j*W +: W] = m_tile[m_rb][r][j*W +: W];
                end
            end
            e_done[t+l+SC-1] = 1;
            m_done_cyc = t + l + SC - 1;
            m_act = 1;
`ifdef WFEED_REPLAY_EN
            m_keep = kp;
`else
            m_keep = 0;
`endif
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("rst_o_valid", 64'(o_valid), 64'd0);
        check("rst_o_data", 64'(o_data), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_bank_full", 64'(bank_full), 64'd0);
        wr_valid = 0; wr_last = 0; start = 0; keep = 0; wr_data = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        wr_valid = 0; wr_last = 0; start = 0; keep = 0; wr_data = '0;
        model_reset();
        #2;
        check("init_o_valid", 64'(o_valid), 64'd0);
        check("init_o_data", 64'(o_data), 64'd0);
        check("init_done", 64'(done), 64'd0);
        check("init_bank_full", 64'(bank_full), 64'd0);
        check("init_start_ready", 64'(start_ready), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        // start with nothing loaded is ignored
        for (int i = 0; i < 4; i++) step(0, '0, 0, 1, 0);

        // 3-row tile, stream it
        for (int r = 0; r < 3; r++) step(1, mkrow(r), r == 2, 0, 0);
        step(0, '0, 0, 0, 0);
        step(0, '0, 0, 1, 0);
        idle(10);

        // both banks filled, third load held off, back-to-back streams
        for (int k = 0; k < 2; k++) step(1, mkrow(4 + k), k == 1, 0, 0);
        for (int k = 0; k < 5; k++) step(1, mkrow(8 + k), k == 4, 0, 0);
        for (int k = 0; k < 30; k++) step(1, mkrow(13 + (k % 3)), k == 3, 1, 0);
        idle(15);

        // implicit close at DEPTH rows, spill into the other bank
        for (int k = 0; k < 10; k++) step(1, mkrow(k + 1), 0, 0, 0);
        for (int k = 0; k < 20; k++) step(0, '0, 0, 1, 0);
        step(1, mkrow(15), 1, 0, 0);
        for (int k = 0; k < 15; k++) step(0, '0, 0, 1, 0);

        // reset while streaming row 1
        for (int r = 0; r < 3; r++) step(1, mkrow(r + 2), r == 2, 0, 0);
        step(0, '0, 0, 0, 0);
        step(0, '0, 0, 1, 0);
        do_reset();
        idle(8);
        for (int r = 0; r < 2; r++) step(1, mkrow(r + 6), r == 1, 0, 0);
        step(0, '0, 0, 1, 0);
        idle(10);

`ifdef WFEED_REPLAY_EN
        for (int r = 0; r < 2; r++) step(1, mkrow(r + 9), r == 1, 0, 0);
        step(0, '0, 0, 1, 1);
        idle(8);
        step(0, '0, 0, 1, 1);
        idle(8);
        step(0, '0, 0, 1, 0);
        idle(10);
`endif

        for (int i = 0; i < 400; i++) begin
            step(1'($urandom % 2), {$urandom}, 1'($urandom % 4 == 0), 1'($urandom % 3 == 0), 1'($urandom % 2));
        end
        idle(20);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/skewed_weight_feeder.md
Name: skewed_weight_feeder

Overview:
- Next-generation weight source for the systolic array. Weights arrive over a valid/ready load port and are stored in two ping-pong banks; they are not preloaded from files.
- On a start handshake, one bank streams a tile into the array top edge. Column j is delayed j cycles to give the diagonal skew the PE grid expects.
- Loading of the next tile overlaps streaming of the current one.
- Replaces the fixed-file, per-column FIFO feeder.

Parameters:
- SYS_COLS, default sys_cols: number of array columns (output lanes).
- W_BITWIDTH, default W_BITWIDTH: weight width in bits.
- DEPTH, default w_buffer_depth: maximum rows per tile, per bank.

Ports:
- clk  in  1  clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- wr_valid  in  1  load beat valid.
- wr_ready  out  1  load beat accepted when wr_valid && wr_ready.
- wr_data  in  SYS_COLS*W_BITWIDTH  one tile row, lane j = column j.
- wr_last  in  1  marks the final row of the tile being loaded.
- start  in  1  request to stream the next full bank.
- start_ready  out  1  start accepted when start && start_ready.
- o_valid  out  SYS_COLS  per-column valid, skewed.
- o_data  out  SYS_COLS*W_BITWIDTH  per-column weight, skewed.
- done  out  1  one-cycle pulse on the last valid of column SYS_COLS-1.
- bank_full  out  2  full flag of bank 0 and bank 1.

Behaviour:
- Reset (rst low, asynchronous): clear every register.
  - wr_ready=1 after release, start_ready=0, o_valid=0, o_data=0, done=0, bank_full=0.
  - wr_bank=0, rd_bank=0, write row counter=0, state=IDLE.
- State per bank: full flag and len (1..DEPTH).
- Load:
  - wr_ready = !full[wr_bank].
  - An accepted beat writes row wr_cnt of wr_bank; wr_cnt increments.
  - A tile closes on an accepted beat with wr_last, or on the beat where wr_cnt==DEPTH-1 (implicit last, extra rows need a new tile).
  - On close: full[wr_bank]<=1, len<=wr_cnt+1, wr_cnt<=0, wr_bank toggles.
- FSM IDLE -> STREAM -> DRAIN -> IDLE:
  - IDLE: start_ready = full[rd_bank]. An accepted start at cycle T latches len and goes to STREAM.
  - STREAM: reads row r=0..len-1 of rd_bank at cycles T..T+len-1; column 0 data is registered out one cycle later. After row len-1 is read, go to DRAIN.
  - DRAIN: wait SYS_COLS-1 cycles for the skew lines to empty, then go to IDLE.
  - If SYS_COLS==1, skip DRAIN.
- Timing:
  - o_valid[j] is high exactly for cycles T+1+j .. T+len+j.
  - o_data[j] at cycle T+1+j+r = row r, lane j.
  - done pulses at cycle T+len+SYS_COLS-1.
  - In the same cycle as done: full[rd_bank]<=0 and rd_bank toggles. start_ready can rise the next cycle, and only if the other bank is full.
- o_data[j] is 0 whenever o_valid[j] is 0 (base build).
- Simultaneous events:
  - Loading into wr_bank while streaming rd_bank is legal.
  - Load closing on the same cycle that done frees the other bank: both updates apply.
  - Both banks full: wr_ready=0 until done.
  - start while start_ready=0 is ignored and not queued.
- Reset mid-stream or mid-load discards all tiles; no done is generated.

Optional Feature:
- Macro: WFEED_REPLAY_EN (weight reuse across activation tiles).
- With the macro: input port keep (1 bit) is sampled with the accepted start. If keep=1, done still pulses but full[rd_bank] stays set and rd_bank does not toggle, so the next start replays the same tile.
- Without the macro: port keep does not exist, and every done releases and toggles the bank.

Decomposition:
- Package Config gains:
  - typedef w_row_t: logic [sys_cols-1:0][W_BITWIDTH-1:0].
  - localparam W_LEN_BITS = $clog2(w_buffer_depth+1).
  - typedef enum wfeed_state_t {IDLE, STREAM, DRAIN}.
- Sub-module wfeed_skew_line #(DELAY, WIDTH): a DELAY-stage register pipe carrying {valid, data} with asynchronous active-low reset. DELAY=0 is a wire. Instantiate one per column j with DELAY=j.
- Bank storage is inferred memory inside the top module.

Test Plan (SYS_COLS=4, DEPTH=8, W_BITWIDTH=8):
- Load 3 rows {row r lane j = 16r+j} with wr_last on row 2, then start -> o_valid[0] high cycles T+1..T+3, o_valid[3] high T+4..T+6, o_data[3]=0x03,0x13,0x23, done at T+6, bank_full[0] cleared.
- Load bank0 (2 rows) then bank1 (5 rows) back-to-back, attempt a third load -> wr_ready=0 after bank1 closes; first stream gives len 2, second gives len 5; wr_ready returns the cycle after the first done.
- Load 10 beats without wr_last -> tile closes at beat 8 with len=8; beats 9-10 go to the other bank.
- Start with no full bank -> start_ready=0, o_valid stays 0, no done; later load plus start streams normally.
- Deassert rst during STREAM at row 1 -> o_valid and o_data go 0 immediately, bank_full=0, no done; a fresh load/start works.
- WFEED_REPLAY_EN: start with keep=1 twice, then keep=0 -> three identical streams, the bank is freed only after the third done.
